// File: rtl/calc_arbiter.sv
// Round-robin arbiter sequencing NREQ requesters onto one shared iterative
// calculator core, with divide-by-zero screening and a done timeout.
module calc_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [NREQ-1:0]   Req,
    input  logic [2*NREQ-1:0] ReqOp,
    input  logic [W*NREQ-1:0] ReqA,
    input  logic [W*NREQ-1:0] ReqB,
    output logic [NREQ-1:0]   Gnt,
    output logic [NREQ-1:0]   RespValid,
    output logic [W:0]        Result,
    output logic              RespFlag,
    output logic              RespErr,
    output logic              CoreStart,
    output logic [1:0]        CoreOp,
    output logic [W-1:0]      CoreA,
    output logic [W-1:0]      CoreB,
    input  logic              CoreDone,
    input  logic [W:0]        CoreC,
    input  logic              CoreFlag,
    output logic              Busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_ISSUE = 4'b0010,
        S_WAIT  = 4'b0100,
        S_RESP  = 4'b1000
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     win_q, win_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   rv_q, rv_d;
    logic [W:0]        res_q, res_d;
    logic              flag_q, flag_d;
    logic              err_q, err_d;
    logic              start_q, start_d;
    logic [1:0]        op_q, op_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;

    logic              found;
    logic [IW-1:0]     pick;
    logic [IW-1:0]     idx;

    // Scan starts just after the last winner so every requester is reached
    // within NREQ grants.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(ptr_q) + k) % NREQ);
            if (!found && Req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        gnt_d   = '0;
        rv_d    = '0;
        res_d   = res_q;
        flag_d  = flag_q;
        err_d   = err_q;
        start_d = 1'b0;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    win_d   = pick;
                    op_d    = ReqOp[2*pick +: 2];
                    a_d     = ReqA[W*pick +: W];
                    b_d     = ReqB[W*pick +: W];
                    gnt_d   = NREQ'(1) << pick;
                    err_d   = 1'b0;
                    flag_d  = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (op_q == 2'b11 && b_q == '0) begin
                    err_d   = 1'b1;
                    res_d   = '0;
                    state_d = S_RESP;
                end else begin
                    start_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A done arriving on the last allowed cycle still counts.
                if (CoreDone) begin
                    res_d   = CoreC;
                    flag_d  = CoreFlag;
                    state_d = S_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    res_d   = '0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                rv_d    = NREQ'(1) << win_q;
                ptr_d   = win_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= IW'(NREQ - 1);
            win_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            rv_q    <= '0;
            res_q   <= '0;
            flag_q  <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            rv_q    <= rv_d;
            res_q   <= res_d;
            flag_q  <= flag_d;
            err_q   <= err_d;
            start_q <= start_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign Gnt       = gnt_q;
    assign RespValid = rv_q;
    assign Result    = res_q;
    assign RespFlag  = flag_q;
    assign RespErr   = err_q;
    assign CoreStart = start_q;
    assign CoreOp    = op_q;
    assign CoreA     = a_q;
    assign CoreB     = b_q;
    assign Busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_calc_arbiter.sv
// Bench for calc_arbiter: transaction-schedule reference model, per-cycle
// compare, a behavioural calculator core, directed and random stimulus.
module tb_calc_arbiter;

    localparam int NREQ    = 4;
    localparam int W       = 16;
    localparam int TIMEOUT = 64;

    logic              Clk = 1'b0;
    logic              Reset_n = 1'b0;
    logic [NREQ-1:0]   Req = '0;
    logic [2*NREQ-1:0] ReqOp = '0;
    logic [W*NREQ-1:0] ReqA = '0;
    logic [W*NREQ-1:0] ReqB = '0;
    logic [NREQ-1:0]   Gnt;
    logic [NREQ-1:0]   RespValid;
    logic [W:0]        Result;
    logic              RespFlag;
    logic              RespErr;
    logic              CoreStart;
    logic [1:0]        CoreOp;
    logic [W-1:0]      CoreA;
    logic [W-1:0]      CoreB;
    logic              CoreDone = 1'b0;
    logic [W:0]        CoreC = '0;
    logic              CoreFlag = 1'b0;
    logic              Busy;

    calc_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .ReqOp(ReqOp),
        .ReqA(ReqA), .ReqB(ReqB), .Gnt(Gnt), .RespValid(RespValid),
        .Result(Result), .RespFlag(RespFlag), .RespErr(RespErr),
        .CoreStart(CoreStart), .CoreOp(CoreOp), .CoreA(CoreA),
        .CoreB(CoreB), .CoreDone(CoreDone), .CoreC(CoreC),
        .CoreFlag(CoreFlag), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int lat_force = 0;
    bit hang = 1'b0;
    bit stray_en = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     nm, cyc, act, exp);
        end
    endtask

    // {flag, result[16:0]} as the calculator core defines them
    function automatic logic [17:0] calc(input logic [1:0] op,
                                         input logic [15:0] a,
                                         input logic [15:0] b);
        logic [31:0] p;
        logic [16:0] c;
        logic        f;
        case (op)
            2'd0: begin p = a + b; c = p[16:0]; f = p[16]; end
            2'd1: begin c = {1'b0, a} - {1'b0, b}; f = (a < b); end
            2'd2: begin p = a * b; c = p[16:0]; f = |p[31:17]; end
            default: begin
                c = (b == 0) ? 17'd0 : 17'(a / b);
                f = (b == 0) ? 1'b0 : ((a % b) != 0);
            end
        endcase
        return {f, c};
    endfunction

    function automatic int lat_of(input logic [15:0] a, input logic [15:0] b);
        if (lat_force != 0) return lat_force;
        return 1 + int'((a ^ b) % 16'd7);
    endfunction

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Behavioural core: done L cycles after the start cycle; stray dones
    // only while it has no operation in hand.
    bit          c_active = 1'b0;
    int          c_cnt = 0;
    logic [1:0]  c_op;
    logic [15:0] c_a, c_b;
    always @(negedge Clk) begin
        CoreDone = 1'b0;
        if (!Reset_n) begin
            c_active = 1'b0;
        end else if (c_active) begin
            c_cnt--;
            if (c_cnt == 0) begin
                {CoreFlag, CoreC} = calc(c_op, c_a, c_b);
                CoreDone = 1'b1;
                c_active = 1'b0;
            end
        end else if (CoreStart) begin
            if (!hang) begin
                c_active = 1'b1;
                c_cnt = lat_of(CoreA, CoreB);
                c_op = CoreOp;
                c_a = CoreA;
                c_b = CoreB;
            end
        end else if (stray_en && $urandom_range(0, 7) == 0) begin
            CoreDone = 1'b1;
            CoreC = 17'($urandom);
            CoreFlag = 1'($urandom);
        end
    end

    // Reference model: at each grant, schedule the edges of the whole
    // transaction from the documented latencies.
    bit          m_busy;
    int          m_ptr, m_win, m_g, m_start, m_res, m_rv, m_free;
    logic [1:0]  e_op;
    logic [15:0] e_a, e_b;
    logic [16:0] e_res, p_res;
    logic        e_flag, e_err, p_flag, p_err;

    task automatic model_reset();
        m_busy = 0; m_ptr = NREQ - 1; m_win = 0;
        m_g = -1; m_start = -1; m_res = -1; m_rv = -1; m_free = -1;
        e_op = '0; e_a = '0; e_b = '0;
        e_res = '0; e_flag = 0; e_err = 0;
    endtask

    initial model_reset();

    always @(posedge Clk) begin
        int best, bestd, d, L;
        cyc++;
        if (!Reset_n) begin
            model_reset();
        end else begin
            if (m_busy && cyc == m_res) begin
                e_res = p_res; e_flag = p_flag; e_err = p_err;
            end
            if (m_busy && cyc == m_rv) m_ptr = m_win;
            if (m_busy && cyc == m_free) m_busy = 0;
            if (!m_busy && Req != 0) begin
                best = 0; bestd = NREQ + 1;
                for (int j = 0; j < NREQ; j++) begin
                    d = (j - m_ptr - 1 + 2 * NREQ) % NREQ;
                    if (Req[j] && d < bestd) begin best = j; bestd = d; end
                end
                m_win = best; m_g = cyc; m_busy = 1;
                e_op = ReqOp[2*best +: 2];
                e_a = ReqA[W*best +: W];
                e_b = ReqB[W*best +: W];
                e_err = 0; e_flag = 0;
                if (e_op == 2'd3 && e_b == 0) begin
                    m_start = -1; m_res = cyc + 1;
                    p_res = '0; p_err = 1; p_flag = 0;
                end else begin
                    m_start = cyc + 1;
                    L = hang ? TIMEOUT + 100 : lat_of(e_a, e_b);
                    if (L <= TIMEOUT - 1) begin
                        m_res = cyc + 2 + L;
                        {p_flag, p_res} = calc(e_op, e_a, e_b);
                        p_err = 0;
                    end else begin
                        m_res = cyc + 1 + TIMEOUT;
                        p_res = '0; p_err = 1; p_flag = 0;
                    end
                end
                m_rv = m_res + 1;
                m_free = m_res + 2;
            end
        end
    end

    always @(negedge Clk) begin
        if (!Reset_n) begin
            chk("rst_gnt", Gnt, 0);
            chk("rst_rv", RespValid, 0);
            chk("rst_start", CoreStart, 0);
            chk("rst_busy", Busy, 0);
            chk("rst_result", Result, 0);
            chk("rst_flags", {RespFlag, RespErr}, 0);
            chk("rst_core", {CoreOp, CoreA, CoreB}, 0);
        end else begin
            chk("gnt", Gnt, (m_busy && cyc == m_g) ? oh(m_win) : '0);
            chk("rv", RespValid, (m_busy && cyc == m_rv) ? oh(m_win) : '0);
            chk("start", CoreStart, m_busy && cyc == m_start);
            chk("busy", Busy, m_busy && cyc < m_rv);
            chk("result", Result, e_res);
            chk("flag", RespFlag, e_flag);
            chk("err", RespErr, e_err);
            chk("core_opnd", {CoreOp, CoreA, CoreB}, {e_op, e_a, e_b});
        end
    end

    // Event log used by the directed checks
    logic [NREQ-1:0] gnt_q[$], rv_q[$];
    logic [16:0]     rvres_q[$];
    logic            rverr_q[$];
    int              gcyc_q[$], rvcyc_q[$];
    int              start_cnt = 0, last_start = 0, err_cyc = 0;
    logic            prev_err = 1'b0;
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (Gnt != 0) begin gnt_q.push_back(Gnt); gcyc_q.push_back(cyc); end
            if (CoreStart) begin start_cnt++; last_start = cyc; end
            if (RespValid != 0) begin
                rv_q.push_back(RespValid);
                rvres_q.push_back(Result);
                rverr_q.push_back(RespErr);
                rvcyc_q.push_back(cyc);
            end
            if (RespErr && !prev_err) err_cyc = cyc;
        end
        prev_err = RespErr;
    end

    task automatic clr_logs();
        gnt_q.delete(); rv_q.delete(); rvres_q.delete(); rverr_q.delete();
        gcyc_q.delete(); rvcyc_q.delete(); start_cnt = 0;
    endtask

    task automatic do_reset();
        @(posedge Clk); #2;
        Reset_n = 1'b0;
        Req = '0;
        repeat (2) @(posedge Clk);
        #2 Reset_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [1:0] op,
                           input logic [15:0] a, input logic [15:0] b);
        ReqOp[2*i +: 2] = op;
        ReqA[W*i +: W] = a;
        ReqB[W*i +: W] = b;
    endtask

    task automatic pulse_req(input logic [NREQ-1:0] r);
        Req = r;
        @(posedge Clk); #2;
        Req = '0;
    endtask

    // which: 0 = grants, 1 = responses
    task automatic wait_ev(input string nm, input int which, input int n,
                           input int budget);
        int sz;
        sz = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge Clk); #1;
            sz = (which == 0) ? gnt_q.size() : rv_q.size();
            if (sz >= n) break;
        end
        chk(nm, sz >= n, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rst_left;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_busy", Busy, 0);
        chk("reset_gnt", Gnt, 0);
        #1 Reset_n = 1'b1;

        // single ADD
        clr_logs(); lat_force = 1;
        set_req(0, 2'd0, 16'd5, 16'd7);
        pulse_req(4'b0001);
        wait_ev("t1_wait", 1, 1, 20);
        chk("t1_gnt", gnt_q[0], 4'b0001);
        chk("t1_starts", start_cnt, 1);
        chk("t1_rv", rv_q[0], 4'b0001);
        chk("t1_result", rvres_q[0], 12);
        chk("t1_err", rverr_q[0], 0);
        chk("t1_latency", rvcyc_q[0] - gcyc_q[0], 4);

        // divide by zero right after a nonzero result
        @(posedge Clk); #2;
        clr_logs();
        set_req(2, 2'd3, 16'd9, 16'd0);
        pulse_req(4'b0100);
        wait_ev("t4_wait", 1, 1, 20);
        chk("t4_starts", start_cnt, 0);
        chk("t4_rv", rv_q[0], 4'b0100);
        chk("t4_err", rverr_q[0], 1);
        chk("t4_result", rvres_q[0], 0);
        chk("t4_latency", rvcyc_q[0] - gcyc_q[0], 2);

        // two MUL requesters held from reset
        do_reset();
        clr_logs(); lat_force = 3;
        set_req(0, 2'd2, 16'd3, 16'd4);
        set_req(1, 2'd2, 16'd10, 16'd20);
        Req = 4'b0011;
        wait_ev("t2_wait", 0, 3, 60);
        @(posedge Clk); #2 Req = '0;
        chk("t2_g0", gnt_q[0], 4'b0001);
        chk("t2_g1", gnt_q[1], 4'b0010);
        chk("t2_g2", gnt_q[2], 4'b0001);
        chk("t2_res0", rvres_q[0], 12);
        chk("t2_res1", rvres_q[1], 200);

        // all four requesting continuously
        do_reset();
        clr_logs(); lat_force = 1;
        for (int i = 0; i < NREQ; i++) set_req(i, 2'd0, 16'(i + 1), 16'd1);
        Req = 4'b1111;
        wait_ev("t3_wait", 0, 5, 80);
        @(posedge Clk); #2 Req = '0;
        wait_ev("t3_drain", 1, 5, 40);
        chk("t3_g0", gnt_q[0], 4'b0001);
        chk("t3_g1", gnt_q[1], 4'b0010);
        chk("t3_g2", gnt_q[2], 4'b0100);
        chk("t3_g3", gnt_q[3], 4'b1000);
        chk("t3_g4", gnt_q[4], 4'b0001);
        chk("t3_res3", rvres_q[3], 5);

        // core never answers
        @(posedge Clk); #2;
        clr_logs(); hang = 1; stray_en = 0;
        set_req(0, 2'd0, 16'd1, 16'd2);
        pulse_req(4'b0001);
        wait_ev("t5_wait", 1, 1, 120);
        chk("t5_err", rverr_q[0], 1);
        chk("t5_result", rvres_q[0], 0);
        chk("t5_err_delay", err_cyc - last_start, TIMEOUT);
        chk("t5_rv_delay", rvcyc_q[0] - last_start, TIMEOUT + 1);
        @(posedge Clk); #2;
        chk("t5_idle", Busy, 0);
        hang = 0; stray_en = 1;

        // done one cycle too late, then exactly on the last cycle
        clr_logs(); lat_force = TIMEOUT;
        set_req(1, 2'd0, 16'd100, 16'd23);
        pulse_req(4'b0010);
        wait_ev("t6a_wait", 1, 1, 120);
        chk("t6a_err", rverr_q[0], 1);
        chk("t6a_result", rvres_q[0], 0);
        @(posedge Clk); #2;
        clr_logs(); lat_force = TIMEOUT - 1;
        pulse_req(4'b0010);
        wait_ev("t6b_wait", 1, 1, 120);
        chk("t6b_err", rverr_q[0], 0);
        chk("t6b_result", rvres_q[0], 123);

        // reset while waiting on the core
        @(posedge Clk); #2;
        clr_logs(); lat_force = 20;
        set_req(1, 2'd1, 16'd50, 16'd8);
        pulse_req(4'b0010);
        repeat (5) @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        chk("t7_busy", Busy, 0);
        chk("t7_result", Result, 0);
        chk("t7_core", {CoreOp, CoreA}, 0);
        repeat (2) @(posedge Clk);
        #2 Reset_n = 1'b1;
        clr_logs();
        repeat (30) @(posedge Clk);
        #2;
        chk("t7_no_rv", rv_q.size(), 0);
        lat_force = 2;
        set_req(3, 2'd0, 16'd1000, 16'd24);
        pulse_req(4'b1000);
        wait_ev("t7_wait", 1, 1, 20);
        chk("t7_gnt", gnt_q[0], 4'b1000);
        chk("t7_rv", rv_q[0], 4'b1000);
        chk("t7_res", rvres_q[0], 1024);

        // random traffic
        @(posedge Clk); #2;
        lat_force = 0;
        rst_left = 0;
        for (int n = 0; n < 4000; n++) begin
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) Reset_n = 1'b1;
            end else if ($urandom_range(0, 499) == 0) begin
                Reset_n = 1'b0;
                rst_left = 2;
            end
            if ($urandom_range(0, 3) == 0) Req = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    set_req(i, 2'($urandom),
                            ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 40))
                                                        : 16'($urandom),
                            ($urandom_range(0, 5) == 0) ? 16'd0
                                                        : 16'($urandom_range(1, 300)));
                end
            end
            @(posedge Clk); #2;
        end
        Reset_n = 1'b1;
        Req = '0;
        repeat (20) @(posedge Clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
